sdram_port_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 44 ++++
 rtl/arb_id_fifo.sv | 58 +++++
 rtl/sdram_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM arbiter.
//   - arb_state_e : arbiter FSM states
//   - req_id_t    : requester identifier (0 = Nios data path, 1 = second master)
//   - arb_cmd_t   : one Avalon-MM command as captured for the controller
//   - make_cmd    : builds a command; read+write together is resolved as a write
package sdram_arb_pkg;

    // The command struct fixes the port widths of the arbiter.
    localparam int unsigned ARB_ADDR_W = 25;
    localparam int unsigned ARB_DATA_W = 32;
    localparam int unsigned ARB_BE_W   = ARB_DATA_W / 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef logic req_id_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] address;
        logic                  read;
        logic                  write;
        logic [ARB_DATA_W-1:0] writedata;
        logic [ARB_BE_W-1:0]   byteenable;
    } arb_cmd_t;

    function automatic arb_cmd_t make_cmd(
        input logic [ARB_ADDR_W-1:0] address,
        input logic                  read,
        input logic                  write,
        input logic [ARB_DATA_W-1:0] writedata,
        input logic [ARB_BE_W-1:0]   byteenable
    );
        arb_cmd_t c;
        c.address    = address;
        c.read       = read & ~write;  // illegal read+write is taken as a write
        c.write      = write;
        c.writedata  = writedata;
        c.byteenable = byteenable;
        return c;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// Synchronous FIFO of requester IDs, one entry per outstanding read.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   push, push_id  : append an ID (push while full is allowed only together with pop)
//   pop, head_id   : remove the head; head_id is the current head (valid when !empty)
//   count          : number of stored IDs (0..DEPTH)
//   empty, full    : status flags
module arb_id_fifo
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  req_id_t          push_id,
    input  logic             pop,
    output req_id_t          head_id,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    req_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_id;
    end

    assign head_id = mem[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester Avalon-MM arbiter in front of the single SDRAM controller slave.
// Round-robin grant per command, pipelined reads, read data routed back by a FIFO
// of requester IDs.
// Ports:
//   clk_clk, reset_reset           : clock, synchronous active-high reset
//   r0_* / r1_*                    : requester slave ports (0 = Nios data, 1 = second master)
//   m_*                            : master port to the SDRAM controller
//   orphan_rd                      : sticky flag, read data arrived with nothing pending
//   grant_cnt0/1, stall_cnt        : performance counters, present only when the
//                                    ARB_PERF_EN macro is defined
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ARB_ADDR_W,
    parameter int unsigned DATA_W      = ARB_DATA_W,
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [ADDR_W-1:0]   r0_address,
    input  logic                r0_read,
    input  logic                r0_write,
    input  logic [DATA_W-1:0]   r0_writedata,
    input  logic [DATA_W/8-1:0] r0_byteenable,
    output logic                r0_waitrequest,
    output logic [DATA_W-1:0]   r0_readdata,
    output logic                r0_readdatavalid,
    input  logic [ADDR_W-1:0]   r1_address,
    input  logic                r1_read,
    input  logic                r1_write,
    input  logic [DATA_W-1:0]   r1_writedata,
    input  logic [DATA_W/8-1:0] r1_byteenable,
    output logic                r1_waitrequest,
    output logic [DATA_W-1:0]   r1_readdata,
    output logic                r1_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
`ifdef ARB_PERF_EN
    output logic [31:0]         grant_cnt0,
    output logic [31:0]         grant_cnt1,
    output logic [31:0]         stall_cnt,
`endif
    output logic                orphan_rd
);

    localparam int unsigned CNT_W = $clog2(MAX_PENDING) + 1;

    arb_state_e state_q, state_d;
    req_id_t    grant_q, grant_d;
    req_id_t    last_grant_q, last_grant_d;
    arb_cmd_t   cmd_q, cmd_d;

    logic             accept;
    logic             read_ok;
    logic             elig0, elig1;
    logic             fifo_push, fifo_pop;
    logic             fifo_empty, fifo_full;
    req_id_t          head_id;
    logic [CNT_W-1:0] pend_cnt;

    logic              r0_rdv_q, r1_rdv_q;
    logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q;
    logic              orphan_q;

    assign accept  = (state_q == ARB_BUSY) && !m_waitrequest;
    assign read_ok = (pend_cnt < CNT_W'(MAX_PENDING));
    assign elig0   = r0_write || (r0_read && read_ok);
    assign elig1   = r1_write || (r1_read && read_ok);

    // Same-cycle pop frees the slot that a push at full would need.
    assign fifo_push = accept && cmd_q.read && (!fifo_full || fifo_pop);
    assign fifo_pop  = m_readdatavalid && !fifo_empty;

    // State register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;  // requester 0 wins the first contention
            cmd_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (elig0 || elig1) begin
                    grant_d = (elig0 && elig1) ? ~last_grant_q : req_id_t'(elig1);
                    cmd_d   = grant_d ? make_cmd(r1_address, r1_read, r1_write,
                                                 r1_writedata, r1_byteenable)
                                      : make_cmd(r0_address, r0_read, r0_write,
                                                 r0_writedata, r0_byteenable);
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!m_waitrequest) begin
                    last_grant_d = grant_q;
                    cmd_d.read   = 1'b0;
                    cmd_d.write  = 1'b0;
                    state_d      = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        m_address      = cmd_q.address;
        m_read         = cmd_q.read;
        m_write        = cmd_q.write;
        m_writedata    = cmd_q.writedata;
        m_byteenable   = cmd_q.byteenable;
        r0_waitrequest = !(accept && (grant_q == 1'b0));
        r1_waitrequest = !(accept && (grant_q == 1'b1));
    end

    arb_id_fifo #(
        .DEPTH (MAX_PENDING),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk     (clk_clk),
        .reset   (reset_reset),
        .push    (fifo_push),
        .push_id (grant_q),
        .pop     (fifo_pop),
        .head_id (head_id),
        .count   (pend_cnt),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Read-data return path; readdata holds between strobes.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r0_rdv_q   <= 1'b0;
            r1_rdv_q   <= 1'b0;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
            orphan_q   <= 1'b0;
        end else begin
            r0_rdv_q <= fifo_pop && (head_id == 1'b0);
            r1_rdv_q <= fifo_pop && (head_id == 1'b1);
            if (fifo_pop && (head_id == 1'b0)) r0_rdata_q <= m_readdata;
            if (fifo_pop && (head_id == 1'b1)) r1_rdata_q <= m_readdata;
            if (m_readdatavalid && fifo_empty) orphan_q <= 1'b1;
        end
    end

    assign r0_readdatavalid = r0_rdv_q;
    assign r1_readdatavalid = r1_rdv_q;
    assign r0_readdata      = r0_rdata_q;
    assign r1_readdata      = r1_rdata_q;
    assign orphan_rd        = orphan_q;

`ifdef ARB_PERF_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            stall_cnt  <= '0;
        end else begin
            if (accept && (grant_q == 1'b0)) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (accept && (grant_q == 1'b1)) grant_cnt1 <= grant_cnt1 + 32'd1;
            if ((state_q == ARB_BUSY) && m_waitrequest) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios followed by a
// randomized phase checked against a transaction-level model (per-requester
// command holding, a queue of outstanding read owners, expected return data).
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int MAXP   = 4;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [ADDR_W-1:0] r0_address, r1_address, m_address;
    logic              r0_read, r0_write, r1_read, r1_write;
    logic [DATA_W-1:0] r0_writedata, r1_writedata, m_writedata;
    logic [BE_W-1:0]   r0_byteenable, r1_byteenable, m_byteenable;
    logic              r0_waitrequest, r1_waitrequest;
    logic [DATA_W-1:0] r0_readdata, r1_readdata;
    logic              r0_readdatavalid, r1_readdatavalid;
    logic              m_read, m_write, m_waitrequest, m_readdatavalid;
    logic [DATA_W-1:0] m_readdata;
    logic              orphan_rd;
`ifdef ARB_PERF_EN
    logic [31:0]       grant_cnt0, grant_cnt1, stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_clk = ~clk_clk;

    sdram_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .r0_address       (r0_address),
        .r0_read          (r0_read),
        .r0_write         (r0_write),
        .r0_writedata     (r0_writedata),
        .r0_byteenable    (r0_byteenable),
        .r0_waitrequest   (r0_waitrequest),
        .r0_readdata      (r0_readdata),
        .r0_readdatavalid (r0_readdatavalid),
        .r1_address       (r1_address),
        .r1_read          (r1_read),
        .r1_write         (r1_write),
        .r1_writedata     (r1_writedata),
        .r1_byteenable    (r1_byteenable),
        .r1_waitrequest   (r1_waitrequest),
        .r1_readdata      (r1_readdata),
        .r1_readdatavalid (r1_readdatavalid),
        .m_address        (m_address),
        .m_read           (m_read),
        .m_write          (m_write),
        .m_writedata      (m_writedata),
        .m_byteenable     (m_byteenable),
        .m_waitrequest    (m_waitrequest),
        .m_readdata       (m_readdata),
        .m_readdatavalid  (m_readdatavalid),
`ifdef ARB_PERF_EN
        .grant_cnt0       (grant_cnt0),
        .grant_cnt1       (grant_cnt1),
        .stall_cnt        (stall_cnt),
`endif
        .orphan_rd        (orphan_rd)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        r0_address = '0; r0_read = 0; r0_write = 0; r0_writedata = '0; r0_byteenable = '0;
        r1_address = '0; r1_read = 0; r1_write = 0; r1_writedata = '0; r1_byteenable = '0;
        m_waitrequest = 0; m_readdatavalid = 0; m_readdata = '0;
    endtask

    // Leaves the bench at a negedge with reset released and inputs idle.
    task automatic do_reset();
        @(negedge clk_clk);
        clear_inputs();
        reset_reset = 1;
        @(negedge clk_clk);
        reset_reset = 0;
    endtask

    // Random-phase model state
    logic              has [2];
    logic              crd [2];
    logic              cwr [2];
    logic [ADDR_W-1:0] cad [2];
    logic [DATA_W-1:0] cwd [2];
    logic [BE_W-1:0]   cbe [2];
    int                waitc [2];
    logic [DATA_W-1:0] last_rd [2];
    logic              owner_q [$];
    logic              exp_v;
    logic              exp_id;
    logic [DATA_W-1:0] exp_d;
    int                accepted;

    initial begin
        clear_inputs();
        reset_reset = 1;
        @(negedge clk_clk);
        do_reset();
        #1;
        chk("rst_m_read", 64'(m_read), 64'h0);
        chk("rst_m_write", 64'(m_write), 64'h0);
        chk("rst_m_address", 64'(m_address), 64'h0);
        chk("rst_r0_wait", 64'(r0_waitrequest), 64'h1);
        chk("rst_r1_wait", 64'(r1_waitrequest), 64'h1);
        chk("rst_rdv", 64'({r0_readdatavalid, r1_readdatavalid}), 64'h0);
        chk("rst_orphan", 64'(orphan_rd), 64'h0);

        // Single write
        r0_write = 1; r0_address = 25'h10; r0_writedata = 32'hDEADBEEF; r0_byteenable = 4'hF;
        #1;
        chk("wr_c0_m_write", 64'(m_write), 64'h0);
        chk("wr_c0_r0_wait", 64'(r0_waitrequest), 64'h1);
        @(negedge clk_clk); #1;
        chk("wr_c1_m_write", 64'(m_write), 64'h1);
        chk("wr_c1_m_read", 64'(m_read), 64'h0);
        chk("wr_c1_addr", 64'(m_address), 64'h10);
        chk("wr_c1_data", 64'(m_writedata), 64'hDEADBEEF);
        chk("wr_c1_be", 64'(m_byteenable), 64'hF);
        chk("wr_c1_r0_wait", 64'(r0_waitrequest), 64'h0);
        chk("wr_c1_r1_wait", 64'(r1_waitrequest), 64'h1);
        @(negedge clk_clk); r0_write = 0; #1;
        chk("wr_c2_m_write", 64'(m_write), 64'h0);

        // Contention: both read continuously; grants alternate starting with r0
        do_reset();
        r0_read = 1; r0_address = 25'h100; r1_read = 1; r1_address = 25'h200;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk_clk);
            #1;
            chk("rr_r0_wait", 64'(r0_waitrequest),
                64'(!((c % 2 == 1) && ((c / 2) % 2 == 0))));
            chk("rr_r1_wait", 64'(r1_waitrequest),
                64'(!((c % 2 == 1) && ((c / 2) % 2 == 1))));
            if (c % 2 == 1)
                chk("rr_addr", 64'(m_address), ((c / 2) % 2 == 0) ? 64'h100 : 64'h200);
        end

        // Routing of read data
        do_reset();
        r0_read = 1; r0_address = 25'h10; #1;
        @(negedge clk_clk); #1;
        chk("rt_r0_acc", 64'(r0_waitrequest), 64'h0);
        chk("rt_r0_addr", 64'(m_address), 64'h10);
        @(negedge clk_clk); r0_read = 0; r1_read = 1; r1_address = 25'h20; #1;
        @(negedge clk_clk); #1;
        chk("rt_r1_acc", 64'(r1_waitrequest), 64'h0);
        chk("rt_r1_read", 64'(m_read), 64'h1);
        chk("rt_r1_addr", 64'(m_address), 64'h20);
        @(negedge clk_clk); r1_read = 0; m_readdatavalid = 1; m_readdata = 32'hAAAA0000; #1;
        chk("rt_no_early_rdv", 64'(r0_readdatavalid), 64'h0);
        @(negedge clk_clk); m_readdata = 32'hBBBB0000; #1;
        chk("rt_r0_rdv", 64'(r0_readdatavalid), 64'h1);
        chk("rt_r0_data", 64'(r0_readdata), 64'hAAAA0000);
        chk("rt_r1_rdv_lo", 64'(r1_readdatavalid), 64'h0);
        @(negedge clk_clk); m_readdatavalid = 0; m_readdata = '0; #1;
        chk("rt_r1_rdv", 64'(r1_readdatavalid), 64'h1);
        chk("rt_r1_data", 64'(r1_readdata), 64'hBBBB0000);
        chk("rt_r0_rdv_lo", 64'(r0_readdatavalid), 64'h0);
        @(negedge clk_clk); #1;
        chk("rt_idle_rdv", 64'({r0_readdatavalid, r1_readdatavalid}), 64'h0);
        chk("rt_r0_hold", 64'(r0_readdata), 64'hAAAA0000);
        chk("rt_orphan", 64'(orphan_rd), 64'h0);

        // Full FIFO: fifth read is held, a write bypasses it, one return frees it
        do_reset();
        r0_read = 1; r0_address = 25'h40;
        accepted = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk_clk);
            #1;
            if (!r0_waitrequest) accepted++;
        end
        chk("full_accepts", 64'(accepted), 64'd4);
        chk("full_m_read_lo", 64'(m_read), 64'h0);
        @(negedge clk_clk); r1_write = 1; r1_address = 25'h30; r1_writedata = 32'h55; #1;
        @(negedge clk_clk); #1;
        chk("full_wr_acc", 64'(r1_waitrequest), 64'h0);
        chk("full_wr_m_write", 64'(m_write), 64'h1);
        chk("full_wr_addr", 64'(m_address), 64'h30);
        chk("full_r0_held", 64'(r0_waitrequest), 64'h1);
        @(negedge clk_clk); r1_write = 0; m_readdatavalid = 1; m_readdata = 32'h1111; #1;
        chk("full_a_wait", 64'(r0_waitrequest), 64'h1);
        @(negedge clk_clk); m_readdatavalid = 0; #1;
        chk("full_b_rdv", 64'(r0_readdatavalid), 64'h1);
        chk("full_b_m_read", 64'(m_read), 64'h0);
        @(negedge clk_clk); #1;
        chk("full_c_acc", 64'(r0_waitrequest), 64'h0);
        chk("full_c_m_read", 64'(m_read), 64'h1);
        @(negedge clk_clk); r0_read = 0;

        // Wait states: command stable for 3 stalled cycles, accepted in cycle 4
        do_reset();
        r1_write = 1; r1_address = 25'h44; r1_writedata = 32'h12345678; r1_byteenable = 4'h3;
        m_waitrequest = 1; #1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_clk); #1;
            chk("ws_m_write", 64'(m_write), 64'h1);
            chk("ws_addr", 64'(m_address), 64'h44);
            chk("ws_data", 64'(m_writedata), 64'h12345678);
            chk("ws_be", 64'(m_byteenable), 64'h3);
            chk("ws_r1_wait", 64'(r1_waitrequest), 64'h1);
        end
        @(negedge clk_clk); m_waitrequest = 0; #1;
        chk("ws_c4_r1_wait", 64'(r1_waitrequest), 64'h0);
        chk("ws_c4_m_write", 64'(m_write), 64'h1);
        @(negedge clk_clk); r1_write = 0; #1;
        chk("ws_c5_m_write", 64'(m_write), 64'h0);

        // Orphan read data
        do_reset();
        m_readdatavalid = 1; m_readdata = 32'hCAFE; #1;
        @(negedge clk_clk); m_readdatavalid = 0; #1;
        chk("orph_set", 64'(orphan_rd), 64'h1);
        chk("orph_no_rdv", 64'({r0_readdatavalid, r1_readdatavalid}), 64'h0);
        do_reset(); #1;
        chk("orph_clr", 64'(orphan_rd), 64'h0);

        // Randomized traffic against the transaction model
        do_reset();
        for (int r = 0; r < 2; r++) begin
            has[r] = 0; waitc[r] = 0; last_rd[r] = '0;
            crd[r] = 0; cwr[r] = 0; cad[r] = '0; cwd[r] = '0; cbe[r] = '0;
        end
        owner_q.delete();
        exp_v = 0; exp_id = 0; exp_d = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clk_clk);
            for (int r = 0; r < 2; r++) begin
                if (!has[r] && ($urandom_range(0, 2) != 0)) begin
                    int kind;
                    kind   = int'($urandom_range(0, 7));
                    has[r] = 1;
                    crd[r] = (kind <= 3) || (kind == 7);
                    cwr[r] = (kind >= 4);
                    cad[r] = ADDR_W'($urandom);
                    cwd[r] = $urandom;
                    cbe[r] = BE_W'($urandom);
                    waitc[r] = 0;
                end
            end
            r0_read = has[0] & crd[0]; r0_write = has[0] & cwr[0];
            r0_address = cad[0]; r0_writedata = cwd[0]; r0_byteenable = cbe[0];
            r1_read = has[1] & crd[1]; r1_write = has[1] & cwr[1];
            r1_address = cad[1]; r1_writedata = cwd[1]; r1_byteenable = cbe[1];
            m_waitrequest = ($urandom_range(0, 3) == 0);
            m_readdatavalid = (owner_q.size() > 0) && ($urandom_range(0, 1) == 1);
            m_readdata = $urandom;
            #1;

            chk("rnd_r0_rdv", 64'(r0_readdatavalid), 64'(exp_v && (exp_id == 1'b0)));
            chk("rnd_r1_rdv", 64'(r1_readdatavalid), 64'(exp_v && (exp_id == 1'b1)));
            if (exp_v) last_rd[exp_id] = exp_d;
            chk("rnd_r0_data", 64'(r0_readdata), 64'(last_rd[0]));
            chk("rnd_r1_data", 64'(r1_readdata), 64'(last_rd[1]));
            chk("rnd_orphan", 64'(orphan_rd), 64'h0);
            chk("rnd_accept", 64'(!r0_waitrequest || !r1_waitrequest),
                64'((m_read || m_write) && !m_waitrequest));
            chk("rnd_one_acc", 64'(!r0_waitrequest && !r1_waitrequest), 64'h0);

            exp_v = m_readdatavalid;
            if (m_readdatavalid) begin
                exp_id = owner_q.pop_front();
                exp_d  = m_readdata;
            end
            for (int r = 0; r < 2; r++) begin
                logic acc;
                acc = (r == 0) ? !r0_waitrequest : !r1_waitrequest;
                if (has[r]) waitc[r]++;
                if (acc) begin
                    chk("rnd_acc_has", 64'(has[r]), 64'h1);
                    chk("rnd_acc_addr", 64'(m_address), 64'(cad[r]));
                    chk("rnd_acc_rw", 64'({m_read, m_write}), 64'({crd[r] & ~cwr[r], cwr[r]}));
                    if (cwr[r]) begin
                        chk("rnd_acc_wdata", 64'(m_writedata), 64'(cwd[r]));
                        chk("rnd_acc_be", 64'(m_byteenable), 64'(cbe[r]));
                    end
                    chk("rnd_latency", 64'(waitc[r] < 200), 64'h1);
                    if (crd[r] && !cwr[r]) begin
                        owner_q.push_back(r[0]);
                        chk("rnd_pending", 64'(owner_q.size() <= MAXP), 64'h1);
                    end
                    has[r] = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
